// File: rtl/mips_loader_pkg.sv
// ---------------------------------------------------------------------------
// mips_loader_pkg: shared loader FSM states, stream constants, timer sizing.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package mips_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Counter must hold the full reload value TIMEOUT_CYC.
  function automatic int tmo_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/loader_timeout.sv
// ---------------------------------------------------------------------------
// loader_timeout: idle-cycle down-counter, reloaded on kick or while disabled.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module loader_timeout #(
  parameter int CYC = 1000,
  parameter int W   = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= W'(CYC);
    end else if (kick || !enable) begin
      cnt <= W'(CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // High on the edge that would complete CYC idle cycles.
  assign expired = enable && (cnt == W'(1));

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader: byte-stream boot loader into instruction memory; holds the CPU
// in reset until a full image lands. Option macro: IMEM_LOADER_CHECKSUM_EN.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int TW = tmo_width(TIMEOUT_CYC);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CHK;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t            state, state_next;
  logic [7:0]        n_lo;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic              accept;
  logic              loading;
  logic              tmo_enable;
  logic              tmo_expired;
  logic              last_byte;
  logic              last_word;
  logic [16:0]       hdr_n;
  logic              ready_d, cpu_reset_d, done_d, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // rx_ready lags the state by a cycle, so bytes offered after leaving the
  // loading states are dropped here rather than by the handshake.
  assign loading    = (state == S_HDR0) || (state == S_HDR1) ||
                      (state == S_DATA) || (state == S_CHK);
  assign accept     = rx_valid && rx_ready && loading;
  assign tmo_enable = (state == S_HDR1) || (state == S_DATA) || (state == S_CHK);
  assign last_byte  = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign last_word  = (({1'b0, n_words} - 17'd1) == 17'(word_idx));
  assign hdr_n      = {1'b0, rx_data, n_lo};

  loader_timeout #(
    .CYC (TIMEOUT_CYC),
    .W   (TW)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .kick    (accept),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_HDR0;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HDR0: if (accept) state_next = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if (hdr_n == 17'd0)                    state_next = S_AFTER;
          else if (hdr_n > (17'd1 << ADDR_W))    state_next = S_ERROR;
          else                                   state_next = S_DATA;
        end else if (tmo_expired) begin
          state_next = S_ERROR;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (last_byte && last_word) state_next = S_AFTER;
        end else if (tmo_expired) begin
          state_next = S_ERROR;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept)           state_next = (rx_data == csum) ? S_DONE : S_ERROR;
        else if (tmo_expired) state_next = S_ERROR;
      end
`endif
      S_DONE:  state_next = S_DONE;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase
  end

  always_comb begin
    ready_d     = loading;
    cpu_reset_d = (state != S_DONE);
    done_d      = (state == S_DONE);
    error_d     = (state == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rx_ready  <= ready_d;
      cpu_reset <= cpu_reset_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_lo       <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_HDR0: n_lo <= rx_data;
          S_HDR1: begin
            n_words  <= {rx_data, n_lo};
            word_idx <= '0;
            byte_cnt <= '0;
          end
          S_DATA: begin
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_W-1:0];
              imem_wdata <= {rx_data, shift};
              word_idx   <= word_idx + 1'b1;
              byte_cnt   <= '0;
            end else begin
              shift    <= {rx_data, shift[23:8]};
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset)                          csum <= '0;
    else if (accept && state == S_DATA)  csum <= csum ^ rx_data;
  end
`endif

endmodule

`default_nettype wire
